// File: rtl/slave_flow_ctrl.sv
// Per-cluster flow controller: tracks per-slave flow state and arbitrates
// queued core load calls and master flow starts onto one segment-loader port.

module slave_flow_lane #(
    parameter int SEG4_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_call_i,
    input  logic [SEG4_W-1:0] core_seg_i,
    input  logic              clr_i,
    input  logic              set_act_i,
    input  logic              grant_i,
    input  logic              inflight_i,
    input  logic              en_i,
    output logic              active_o,
    output logic              pend_o,
    output logic              busy_o,
    output logic [SEG4_W-1:0] seg_o,
    output logic              clk_en_o
);
    logic              active_q, active_d;
    logic              pend_q, pend_d;
    logic [SEG4_W-1:0] seg_q;
    logic              clk_en_q;
    logic              cap;

    assign busy_o = !active_q | pend_q | inflight_i;
    // A flow-end clear in the same cycle beats a new call from this slave.
    assign cap    = core_call_i & !busy_o & !clr_i;

    always_comb begin
        active_d = active_q;
        if (clr_i)
            active_d = 1'b0;
        else if (set_act_i)
            active_d = 1'b1;
        pend_d = pend_q;
        if (clr_i)
            pend_d = 1'b0;
        else if (cap)
            pend_d = 1'b1;
        else if (grant_i)
            pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            pend_q   <= 1'b0;
            seg_q    <= '0;
            clk_en_q <= 1'b0;
        end else begin
            active_q <= active_d;
            pend_q   <= pend_d;
            if (cap)
                seg_q <= core_seg_i;
            clk_en_q <= en_i & active_d;
        end
    end

    assign active_o = active_q;
    assign pend_o   = pend_q;
    assign seg_o    = seg_q;
    assign clk_en_o = clk_en_q;
endmodule

module slave_flow_ctrl #(
    parameter int              NUM_SLAVES  = 4,
    parameter int              ID_W        = $clog2(NUM_SLAVES),
    parameter int              SEG_W       = 16,
    parameter int              OPC_W       = 6,
    parameter logic [OPC_W-1:0] COM_INTFLOW = 6'h3F
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_SLAVES-1:0]         CORE_CALL,
    input  logic [NUM_SLAVES*4*SEG_W-1:0] CORE_SEG,
    output logic [NUM_SLAVES-1:0]         CORE_BUSY,
    input  logic                          M_START,
    input  logic [ID_W-1:0]               M_ID,
    input  logic [4*SEG_W-1:0]            M_SEG,
    output logic                          M_ACCEPT,
    output logic                          M_REJECT,
    output logic                          LD_CALL,
    output logic [ID_W-1:0]               LD_ID,
    output logic [4*SEG_W-1:0]            LD_SEG,
    input  logic                          LD_READY,
    input  logic                          CMD_VALID,
    input  logic [OPC_W-1:0]              CMD_OPC,
    input  logic [ID_W-1:0]               CMD_ID,
    input  logic [NUM_SLAVES-1:0]         EN,
    output logic [NUM_SLAVES-1:0]         CLK_EN,
    output logic [NUM_SLAVES-1:0]         INT
);
    localparam int SEG4_W = 4 * SEG_W;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                              state_q;
    logic                                ld_call_q, ld_core_q;
    logic [ID_W-1:0]                     ld_id_q, rr_q;
    logic [SEG4_W-1:0]                   ld_seg_q;
    logic                                m_acc_q, m_rej_q;
    logic                                mslot_v_q;
    logic [ID_W-1:0]                     mslot_id_q;
    logic [SEG4_W-1:0]                   mslot_seg_q;

    logic [NUM_SLAVES-1:0]               active, pend, clr, set_act, grant, inflight;
    logic [NUM_SLAVES-1:0][SEG4_W-1:0]   lane_seg;
    logic                                accept, pick_v;
    logic [ID_W-1:0]                     pick_id;

    assign accept = M_START && (int'(M_ID) < NUM_SLAVES) && !active[M_ID]
                    && !mslot_v_q && !clr[M_ID];

    // First pending core at or after rr_q, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        pick_v  = 1'b0;
        pick_id = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            idx = (int'(rr_q) + k) % NUM_SLAVES;
            if (!pick_v && pend[idx]) begin
                pick_v  = 1'b1;
                pick_id = ID_W'(idx);
            end
        end
    end

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_lane
        assign clr[i]      = CMD_VALID && (CMD_OPC == COM_INTFLOW) && (CMD_ID == ID_W'(i));
        assign set_act[i]  = accept && (M_ID == ID_W'(i));
        assign grant[i]    = (state_q == IDLE) && !mslot_v_q && pick_v && (pick_id == ID_W'(i));
        assign inflight[i] = (state_q != IDLE) && (ld_id_q == ID_W'(i));

        slave_flow_lane #(.SEG4_W(SEG4_W)) u_lane (
            .clk         (CLK),
            .rst         (RESET),
            .core_call_i (CORE_CALL[i]),
            .core_seg_i  (CORE_SEG[i*SEG4_W +: SEG4_W]),
            .clr_i       (clr[i]),
            .set_act_i   (set_act[i]),
            .grant_i     (grant[i]),
            .inflight_i  (inflight[i]),
            .en_i        (EN[i]),
            .active_o    (active[i]),
            .pend_o      (pend[i]),
            .busy_o      (CORE_BUSY[i]),
            .seg_o       (lane_seg[i]),
            .clk_en_o    (CLK_EN[i])
        );
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            ld_call_q   <= 1'b0;
            ld_core_q   <= 1'b0;
            ld_id_q     <= '0;
            ld_seg_q    <= '0;
            rr_q        <= '0;
            m_acc_q     <= 1'b0;
            m_rej_q     <= 1'b0;
            mslot_v_q   <= 1'b0;
            mslot_id_q  <= '0;
            mslot_seg_q <= '0;
        end else begin
            m_acc_q <= accept;
            m_rej_q <= M_START && !accept;
            if (accept) begin
                mslot_v_q   <= 1'b1;
                mslot_id_q  <= M_ID;
                mslot_seg_q <= M_SEG;
            end
            case (state_q)
                IDLE: begin
                    if (mslot_v_q) begin
                        mslot_v_q <= 1'b0;
                        ld_call_q <= 1'b1;
                        ld_core_q <= 1'b0;
                        ld_id_q   <= mslot_id_q;
                        ld_seg_q  <= mslot_seg_q;
                        state_q   <= ISSUE;
                    end else if (pick_v) begin
                        ld_call_q <= 1'b1;
                        ld_core_q <= 1'b1;
                        ld_id_q   <= pick_id;
                        ld_seg_q  <= lane_seg[pick_id];
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (LD_READY) begin
                        ld_call_q <= 1'b0;
                        state_q   <= IDLE;
                        if (ld_core_q)
                            rr_q <= (int'(ld_id_q) == NUM_SLAVES - 1) ? '0 : ld_id_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign LD_CALL  = ld_call_q;
    assign LD_ID    = ld_id_q;
    assign LD_SEG   = ld_seg_q;
    assign M_ACCEPT = m_acc_q;
    assign M_REJECT = m_rej_q;
    assign INT      = ~active;
endmodule

// File: tb/tb_slave_flow_ctrl.sv
// Directed bench for slave_flow_ctrl: master starts, round-robin core grants,
// loader backpressure, flow-end clears and mid-issue reset.

module tb_slave_flow_ctrl;
    localparam int N = 4;
    localparam int IW = 2;
    localparam int SW = 16;

    logic              CLK = 0, RESET = 1;
    logic [N-1:0]      CORE_CALL = '0;
    logic [N*4*SW-1:0] CORE_SEG;
    logic [N-1:0]      CORE_BUSY;
    logic              M_START = 0;
    logic [IW-1:0]     M_ID = '0;
    logic [4*SW-1:0]   M_SEG = '0;
    logic              M_ACCEPT, M_REJECT, LD_CALL;
    logic [IW-1:0]     LD_ID;
    logic [4*SW-1:0]   LD_SEG;
    logic              LD_READY = 1;
    logic              CMD_VALID = 0;
    logic [5:0]        CMD_OPC = '0;
    logic [IW-1:0]     CMD_ID = '0;
    logic [N-1:0]      EN = '1;
    logic [N-1:0]      CLK_EN, INT;

    int checks = 0, errors = 0;

    slave_flow_ctrl dut (
        .CLK(CLK), .RESET(RESET), .CORE_CALL(CORE_CALL), .CORE_SEG(CORE_SEG),
        .CORE_BUSY(CORE_BUSY), .M_START(M_START), .M_ID(M_ID), .M_SEG(M_SEG),
        .M_ACCEPT(M_ACCEPT), .M_REJECT(M_REJECT), .LD_CALL(LD_CALL), .LD_ID(LD_ID),
        .LD_SEG(LD_SEG), .LD_READY(LD_READY), .CMD_VALID(CMD_VALID), .CMD_OPC(CMD_OPC),
        .CMD_ID(CMD_ID), .EN(EN), .CLK_EN(CLK_EN), .INT(INT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] cseg(input int i);
        return {16'(16'hA0 + i), 16'hB0B0, 16'hC0C0, 16'(16'hD0 + i)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic master_start(input int id, input logic [63:0] seg);
        M_START = 1; M_ID = IW'(id); M_SEG = seg;
        tick();
        chk("m_accept", M_ACCEPT, 1);
        M_START = 0;
        tick(); tick(); tick();
    endtask

    task automatic grant_chk(input int id);
        tick();
        chk("grant_call", LD_CALL, 1);
        chk("grant_id", LD_ID, id);
        chk("grant_seg", LD_SEG, cseg(id));
        tick();
        chk("grant_drop", LD_CALL, 0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) CORE_SEG[i*64 +: 64] = cseg(i);
        tick(); tick();
        RESET = 0;
        chk("rst_ldcall", LD_CALL, 0);
        chk("rst_ldid", LD_ID, 0);
        chk("rst_ldseg", LD_SEG, 0);
        chk("rst_acc", M_ACCEPT, 0);
        chk("rst_rej", M_REJECT, 0);
        chk("rst_clken", CLK_EN, 0);
        chk("rst_int", INT, 4'b1111);
        chk("rst_busy", CORE_BUSY, 4'b1111);

        // Master start to slave 2
        M_START = 1; M_ID = 2; M_SEG = 64'h0001_0002_0003_0004;
        tick();
        M_START = 0;
        chk("t1_accept", M_ACCEPT, 1);
        chk("t1_int", INT, 4'b1011);
        chk("t1_clken", CLK_EN, 4'b0100);
        chk("t1_nocall", LD_CALL, 0);
        tick();
        chk("t1_call", LD_CALL, 1);
        chk("t1_id", LD_ID, 2);
        chk("t1_seg", LD_SEG, 64'h0001_0002_0003_0004);
        chk("t1_acc_pulse", M_ACCEPT, 0);
        tick();
        chk("t1_drop", LD_CALL, 0);
        tick();

        master_start(0, 64'h10);
        master_start(1, 64'h11);
        master_start(3, 64'h13);
        chk("t2_int", INT, 4'b0000);

        // Round robin: 0,1,3 then 0,1 then 3,0,1
        CORE_CALL = 4'b1011; tick(); CORE_CALL = 0;
        chk("t2_busy", CORE_BUSY, 4'b1011);
        grant_chk(0); grant_chk(1); grant_chk(3);
        CORE_CALL = 4'b0011; tick(); CORE_CALL = 0;
        grant_chk(0); grant_chk(1);
        CORE_CALL = 4'b1011; tick(); CORE_CALL = 0;
        grant_chk(3); grant_chk(0); grant_chk(1);

        // Free slave 2, then master vs core priority and reject
        CMD_VALID = 1; CMD_OPC = 6'h3F; CMD_ID = 2;
        tick();
        CMD_VALID = 0;
        chk("t3_int_clr", INT, 4'b0100);
        chk("t3_clken_clr", CLK_EN, 4'b1011);
        M_START = 1; M_ID = 2; M_SEG = 64'hAAAA_BBBB_CCCC_DDDD; CORE_CALL = 4'b0010;
        tick();
        CORE_CALL = 0;
        chk("t3_accept", M_ACCEPT, 1);
        tick();
        M_START = 0;
        chk("t3_reject", M_REJECT, 1);
        chk("t3_noacc", M_ACCEPT, 0);
        chk("t3_mid", LD_ID, 2);
        chk("t3_mseg", LD_SEG, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("t3_int_same", INT, 4'b0000);
        tick();
        chk("t3_drop", LD_CALL, 0);
        chk("t3_rej_pulse", M_REJECT, 0);
        grant_chk(1);

        // Backpressure
        LD_READY = 0; CORE_CALL = 4'b0001;
        tick();
        CORE_CALL = 0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t4_call", LD_CALL, 1);
            chk("t4_id", LD_ID, 0);
            chk("t4_seg", LD_SEG, cseg(0));
            chk("t4_busy", CORE_BUSY[0], 1);
            tick();
        end
        LD_READY = 1;
        tick();
        chk("t4_drop", LD_CALL, 0);
        chk("t4_busy_free", CORE_BUSY[0], 0);

        // Flow-end clear beats simultaneous call
        CMD_VALID = 1; CMD_OPC = 6'h3F; CMD_ID = 1; CORE_CALL = 4'b0010;
        tick();
        CMD_VALID = 0; CORE_CALL = 0;
        chk("t5_int", INT, 4'b0010);
        chk("t5_clken", CLK_EN, 4'b1101);
        chk("t5_busy", CORE_BUSY[1], 1);
        tick(); tick();
        chk("t5_nopend", LD_CALL, 0);

        // Reset mid-issue; rr_q is 1 so slave 3 wins
        LD_READY = 0; CORE_CALL = 4'b1001;
        tick();
        CORE_CALL = 0;
        tick();
        chk("t6_call", LD_CALL, 1);
        chk("t6_id", LD_ID, 3);
        RESET = 1;
        tick();
        RESET = 0; LD_READY = 1;
        chk("t6_drop", LD_CALL, 0);
        chk("t6_int", INT, 4'b1111);
        chk("t6_clken", CLK_EN, 4'b0000);
        tick(); tick(); tick();
        chk("t6_discard", LD_CALL, 0);
        chk("t6_en_noact", CLK_EN, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/slave_flow_ctrl.md
Name: slave_flow_ctrl

Overview:
Per-cluster controller between NUM_SLAVES slave cores, the master and one shared segment loader. It tracks a flow-active flag per slave, raised by a master start and cleared by a COM_INTFLOW command. Core load calls and master flow starts are queued and arbitrated onto the single loader port, with master priority and round-robin among cores. It also produces per-slave interrupt and registered clock-enable signals.

Parameters:
NUM_SLAVES, 4, number of slave cores (2..16)
ID_W, 2, slave index width, equal to clog2(NUM_SLAVES)
SEG_W, 16, width of one segment register (SA/SB/SC/IP)
OPC_W, 6, command opcode width
COM_INTFLOW, 6'h3F, opcode that ends a flow

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
CORE_CALL  in  NUM_SLAVES  per-core load request, one-cycle pulse
CORE_SEG  in  NUM_SLAVES*4*SEG_W  per-core {SA,SB,SC,IP}; core i at slice i
CORE_BUSY  out  NUM_SLAVES  store_busy back to each core
M_START  in  1  master start-new-flow pulse
M_ID  in  ID_W  target slave of M_START
M_SEG  in  4*SEG_W  master {SA,SB,SC,IP}
M_ACCEPT  out  1  start accepted, one-cycle pulse
M_REJECT  out  1  start rejected, one-cycle pulse
LD_CALL  out  1  loader request valid
LD_ID  out  ID_W  slave that owns the request
LD_SEG  out  4*SEG_W  segments for the loader
LD_READY  in  1  loader can accept; transfer on LD_CALL & LD_READY
CMD_VALID  in  1  loader command strobe
CMD_OPC  in  OPC_W  command opcode
CMD_ID  in  ID_W  slave the command belongs to
EN  in  NUM_SLAVES  master run enable per slave
CLK_EN  out  NUM_SLAVES  registered clock enable per slave
INT  out  NUM_SLAVES  1 = slave idle (flow not active)

Behaviour:
- The clock is CLK. RESET is synchronous and active-high.
- Reset values: active=0, pend=0, mslot=0, rr_ptr=0, FSM=IDLE, LD_CALL=0, LD_ID=0, LD_SEG=0, M_ACCEPT=0, M_REJECT=0, CLK_EN=0. INT is all 1.
- Per-slave state: active[i]; pend[i] with a captured segment register; one master slot (mslot valid, id, seg).
- INT[i] = !active[i], combinational.
- CLK_EN[i] is registered as EN[i] & active[i]. It is never a gated clock.
- CORE_BUSY[i] = !active[i] | pend[i] | (FSM!=IDLE & LD_ID==i).
- CORE_CALL[i] is captured into pend[i] only when CORE_BUSY[i]=0. Otherwise it is dropped.
- M_START is accepted when all three hold: active[M_ID]=0, mslot empty, no CMD clear for M_ID this cycle.
  - Accept: next edge sets mslot and active[M_ID]=1, and pulses M_ACCEPT. Latency is 1.
  - Otherwise: M_REJECT pulses next cycle and nothing changes.
- CMD_VALID & CMD_OPC==COM_INTFLOW clears active[CMD_ID] and pend[CMD_ID] at the next edge. The clear wins over a simultaneous CORE_CALL from that slave.
- FSM states:
  - IDLE: if mslot is valid, load LD_* from mslot and clear mslot. Else if any pend, pick the first set index at or after rr_ptr (wrap modulo NUM_SLAVES), load LD_* and clear that pend. Then go to ISSUE. LD_CALL=1 in the cycle after the decision.
  - ISSUE: hold LD_CALL, LD_ID and LD_SEG stable until LD_READY=1. On transfer, LD_CALL=0 next cycle and the FSM returns to IDLE. rr_ptr becomes granted+1 for core grants only; master grants leave it unchanged.
- Minimum request-to-LD_CALL latency is 2 cycles (capture, then decision). Maximum throughput is one transfer every 2 cycles.
- An INTFLOW clear for LD_ID while in ISSUE does not abort the in-flight request.
- RESET asserted mid-ISSUE drops LD_CALL at the next edge and discards all queued work.

Test Plan:
- Reset, then M_START M_ID=2, M_SEG={1,2,3,4} -> M_ACCEPT at +1, INT=4'b1011, LD_CALL at +2 with LD_ID=2, LD_SEG={1,2,3,4}; LD_READY=1 -> LD_CALL low next cycle.
- Slaves 0,1,3 active; CORE_CALL=4'b1011 same cycle; LD_READY=1 -> grants 0,1,3 in order; repeat -> rr order resumes at 0.
- Master start for slave 2 while core 1 pend -> master granted first; second M_START to slave 2 -> M_REJECT, no state change.
- LD_READY=0 for 5 cycles during ISSUE -> LD_CALL/LD_ID/LD_SEG stable; CORE_BUSY[LD_ID]=1 throughout.
- CMD_VALID, CMD_OPC=6'h3F, CMD_ID=1 with CORE_CALL[1] same cycle -> active[1]=0, pend[1]=0, INT[1]=1, CLK_EN[1]=0 next cycle.
- RESET during ISSUE -> LD_CALL=0, INT all 1, CLK_EN all 0 next cycle; EN=1 without active -> CLK_EN stays 0.
